// File: rtl/pipe_ctrl_seq_pkg.sv
// Shared encodings and stage-register payloads for the pipeline control sequencer.
package pipe_ctrl_seq_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned FWD_W   = 2;
    localparam int unsigned OPC_W   = 7;

    // ALU operand source selects.
    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    // Opcodes of the supported instruction subset.
    localparam logic [OPC_W-1:0] OPC_R    = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_SD   = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_ADDI = 7'b0010011;

    // ALUOp encodings: add (ld/sd/addi), subtract (beq), funct-decoded (R-type).
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // Decoder control bundle.
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               memread;
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               regwrite;
    } ctrl_t;

    // ID/EX payload.
    typedef struct packed {
        ctrl_t              ctrl;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
    } idex_t;

    // EX/MEM payload.
    typedef struct packed {
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
        logic [REG_W-1:0]   rd;
    } exmem_t;

    // MEM/WB payload.
    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic [REG_W-1:0]   rd;
    } memwb_t;

endpackage

// File: rtl/pipe_ctrl_seq_forward_unit.sv
// Combinational ALU operand forwarding selects; the EX/MEM producer beats MEM/WB.
module forward_unit
    import pipe_ctrl_seq_pkg::*;
(
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    output logic [FWD_W-1:0] forward_a,
    output logic [FWD_W-1:0] forward_b
);

    function automatic logic [FWD_W-1:0] fwd_pick(
        input logic             m_we,
        input logic [REG_W-1:0] m_rd,
        input logic             w_we,
        input logic [REG_W-1:0] w_rd,
        input logic [REG_W-1:0] rs
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_REG;
        if (m_we && (m_rd != '0) && (m_rd == rs)) begin
            sel = FWD_MEM;
        end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Independent select per operand.
    always_comb begin
        forward_a = fwd_pick(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs1);
        forward_b = fwd_pick(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs2);
    end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer: stage control registers, load-use/branch hazards, event counters.
module pipe_ctrl_seq
    import pipe_ctrl_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               id_branch,
    input  logic               id_memread,
    input  logic               id_memtoreg,
    input  logic               id_memwrite,
    input  logic               id_alusrc,
    input  logic               id_regwrite,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               ex_branch_taken,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               mem_regwrite,
    output logic [REG_W-1:0]   mem_rd,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_rd,
    output logic [FWD_W-1:0]   forward_a,
    output logic [FWD_W-1:0]   forward_b,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    idex_t            idex_q,      idex_d;
    exmem_t           exmem_q,     exmem_d;
    memwb_t           memwb_q,     memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             load_use;
    logic             stall_sel;

    // Load-use detection; a taken branch overrides the stall since the stalled op is wrong-path.
    always_comb begin
        load_use   = idex_q.ctrl.memread && (idex_q.rd != '0) && id_valid &&
                     ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
        stall_sel  = load_use && !ex_branch_taken;
        pc_write   = !stall_sel;
        ifid_write = !stall_sel;
        ifid_flush = ex_branch_taken;
    end

    // Next state of the stage registers and event counters.
    always_comb begin
        idex_d      = '0;
        exmem_d     = '0;
        memwb_d     = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (id_valid && !load_use && !ex_branch_taken) begin
            idex_d.ctrl.aluop    = id_aluop;
            idex_d.ctrl.branch   = id_branch;
            idex_d.ctrl.memread  = id_memread;
            idex_d.ctrl.memtoreg = id_memtoreg;
            idex_d.ctrl.memwrite = id_memwrite;
            idex_d.ctrl.alusrc   = id_alusrc;
            idex_d.ctrl.regwrite = id_regwrite;
            idex_d.rs1           = id_rs1;
            idex_d.rs2           = id_rs2;
            idex_d.rd            = id_rd;
        end

        exmem_d.memread  = idex_q.ctrl.memread;
        exmem_d.memwrite = idex_q.ctrl.memwrite;
        exmem_d.regwrite = idex_q.ctrl.regwrite;
        exmem_d.memtoreg = idex_q.ctrl.memtoreg;
        exmem_d.rd       = idex_q.rd;

        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.rd       = exmem_q.rd;

        if (stall_sel && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_branch_taken && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Stage and counter registers; reset drops all in-flight instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Operand forwarding for the instruction in EX.
    forward_unit u_forward_unit (
        .mem_regwrite (exmem_q.regwrite),
        .mem_rd       (exmem_q.rd),
        .wb_regwrite  (memwb_q.regwrite),
        .wb_rd        (memwb_q.rd),
        .ex_rs1       (idex_q.rs1),
        .ex_rs2       (idex_q.rs2),
        .forward_a    (forward_a),
        .forward_b    (forward_b)
    );

    // Stage outputs straight from the control registers.
    always_comb begin
        ex_aluop     = idex_q.ctrl.aluop;
        ex_alusrc    = idex_q.ctrl.alusrc;
        ex_branch    = idex_q.ctrl.branch;
        mem_memread  = exmem_q.memread;
        mem_memwrite = exmem_q.memwrite;
        mem_regwrite = exmem_q.regwrite;
        mem_rd       = exmem_q.rd;
        wb_regwrite  = memwb_q.regwrite;
        wb_memtoreg  = memwb_q.memtoreg;
        wb_rd        = memwb_q.rd;
        stall_cnt    = stall_cnt_q;
        flush_cnt    = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Directed bench for pipe_ctrl_seq with hand-computed expectations.
module tb_pipe_ctrl_seq;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [1:0]       id_aluop;
    logic             id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             ex_branch_taken;
    logic             pc_write, ifid_write, ifid_flush;
    logic [1:0]       ex_aluop;
    logic             ex_alusrc, ex_branch;
    logic             mem_memread, mem_memwrite, mem_regwrite;
    logic [4:0]       mem_rd;
    logic             wb_regwrite, wb_memtoreg;
    logic [4:0]       wb_rd;
    logic [1:0]       forward_a, forward_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_chk;
    int n_fail;

    pipe_ctrl_seq #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_aluop        (id_aluop),
        .id_branch       (id_branch),
        .id_memread      (id_memread),
        .id_memtoreg     (id_memtoreg),
        .id_memwrite     (id_memwrite),
        .id_alusrc       (id_alusrc),
        .id_regwrite     (id_regwrite),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .ex_aluop        (ex_aluop),
        .ex_alusrc       (ex_alusrc),
        .ex_branch       (ex_branch),
        .mem_memread     (mem_memread),
        .mem_memwrite    (mem_memwrite),
        .mem_regwrite    (mem_regwrite),
        .mem_rd          (mem_rd),
        .wb_regwrite     (wb_regwrite),
        .wb_memtoreg     (wb_memtoreg),
        .wb_rd           (wb_rd),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] aop, input logic br, input logic mr,
                          input logic mtr, input logic mw, input logic as, input logic rw,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v;    id_aluop = aop;   id_branch = br;  id_memread = mr;
        id_memtoreg = mtr; id_memwrite = mw; id_alusrc = as; id_regwrite = rw;
        id_rs1 = rs1;    id_rs2 = rs2;     id_rd = rd;
    endtask

    task automatic set_idle();  set_id(0, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0); endtask
    task automatic set_rtype(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        set_id(1, 2'b10, 0, 0, 0, 0, 0, 1, rs1, rs2, rd);
    endtask
    task automatic set_ld(input logic [4:0] rs1, input logic [4:0] rd);
        set_id(1, 2'b00, 0, 1, 1, 0, 1, 1, rs1, 5'd0, rd);
    endtask
    task automatic set_addi(input logic [4:0] rs1, input logic [4:0] rd);
        set_id(1, 2'b00, 0, 0, 0, 0, 1, 1, rs1, 5'd0, rd);
    endtask

    task automatic drain();
        set_idle();
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        set_rtype(5'd2, 5'd3, 5'd1);
        step();
        step();
        n_chk++; if (ex_aluop !== 2'b00)   begin n_fail++; $display("FAIL reset_ex_aluop: got %b exp 00", ex_aluop); end
        n_chk++; if (ex_alusrc !== 1'b0)   begin n_fail++; $display("FAIL reset_ex_alusrc: got %b exp 0", ex_alusrc); end
        n_chk++; if (mem_regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_mem_regwrite: got %b exp 0", mem_regwrite); end
        n_chk++; if (mem_rd !== 5'd0)      begin n_fail++; $display("FAIL reset_mem_rd: got %0d exp 0", mem_rd); end
        n_chk++; if (wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_wb_regwrite: got %b exp 0", wb_regwrite); end
        n_chk++; if (wb_rd !== 5'd0)       begin n_fail++; $display("FAIL reset_wb_rd: got %0d exp 0", wb_rd); end
        n_chk++; if (stall_cnt !== 4'd0)   begin n_fail++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
        n_chk++; if (flush_cnt !== 4'd0)   begin n_fail++; $display("FAIL reset_flush_cnt: got %0d exp 0", flush_cnt); end
        n_chk++; if (pc_write !== 1'b1)    begin n_fail++; $display("FAIL reset_pc_write: got %b exp 1", pc_write); end
        n_chk++; if (ifid_flush !== 1'b0)  begin n_fail++; $display("FAIL reset_ifid_flush: got %b exp 0", ifid_flush); end
        n_chk++; if (forward_a !== 2'b00 || forward_b !== 2'b00)
            begin n_fail++; $display("FAIL reset_forward: got %b/%b exp 00/00", forward_a, forward_b); end
        reset = 1'b0;
        set_idle();
    endtask

    task automatic test_load_use();
        set_ld(5'd1, 5'd5);
        #1;
        n_chk++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_ld_pc_write: got %b exp 1", pc_write); end
        step();
        n_chk++; if (ex_alusrc !== 1'b1) begin n_fail++; $display("FAIL lu_ld_in_ex: got %b exp 1", ex_alusrc); end
        set_rtype(5'd5, 5'd7, 5'd6);
        #1;
        n_chk++; if (pc_write !== 1'b0)   begin n_fail++; $display("FAIL lu_pc_write: got %b exp 0", pc_write); end
        n_chk++; if (ifid_write !== 1'b0) begin n_fail++; $display("FAIL lu_ifid_write: got %b exp 0", ifid_write); end
        n_chk++; if (ifid_flush !== 1'b0) begin n_fail++; $display("FAIL lu_ifid_flush: got %b exp 0", ifid_flush); end
        step();
        n_chk++; if ({ex_aluop, ex_alusrc, ex_branch} !== 4'b0000)
            begin n_fail++; $display("FAIL lu_bubble: got %b exp 0000", {ex_aluop, ex_alusrc, ex_branch}); end
        n_chk++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d exp 1", stall_cnt); end
        n_chk++; if (mem_memread !== 1'b1 || mem_rd !== 5'd5)
            begin n_fail++; $display("FAIL lu_ld_in_mem: got %b/%0d exp 1/5", mem_memread, mem_rd); end
        n_chk++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b exp 1", pc_write); end
        step();
        n_chk++; if (ex_aluop !== 2'b10) begin n_fail++; $display("FAIL lu_add_in_ex: got %b exp 10", ex_aluop); end
        n_chk++; if (forward_a !== 2'b01) begin n_fail++; $display("FAIL lu_forward_a: got %b exp 01", forward_a); end
        n_chk++; if (forward_b !== 2'b00) begin n_fail++; $display("FAIL lu_forward_b: got %b exp 00", forward_b); end
        n_chk++; if (wb_regwrite !== 1'b1 || wb_memtoreg !== 1'b1 || wb_rd !== 5'd5)
            begin n_fail++; $display("FAIL lu_ld_in_wb: got %b/%b/%0d exp 1/1/5", wb_regwrite, wb_memtoreg, wb_rd); end
        n_chk++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_stall_once: got %0d exp 1", stall_cnt); end
        drain();
    endtask

    task automatic test_forward_priority();
        set_addi(5'd1, 5'd3); step();
        set_addi(5'd1, 5'd3); step();
        set_rtype(5'd3, 5'd3, 5'd4); step();
        n_chk++; if (forward_a !== 2'b10 || forward_b !== 2'b10)
            begin n_fail++; $display("FAIL fwd_mem_prio: got %b/%b exp 10/10", forward_a, forward_b); end
        drain();
        set_addi(5'd1, 5'd0); step();
        set_addi(5'd1, 5'd0); step();
        set_rtype(5'd0, 5'd0, 5'd4); step();
        n_chk++; if (forward_a !== 2'b00 || forward_b !== 2'b00)
            begin n_fail++; $display("FAIL fwd_x0: got %b/%b exp 00/00", forward_a, forward_b); end
        drain();
        set_addi(5'd1, 5'd3); step();
        set_idle();           step();
        set_rtype(5'd3, 5'd9, 5'd4); step();
        n_chk++; if (forward_a !== 2'b01 || forward_b !== 2'b00)
            begin n_fail++; $display("FAIL fwd_wb_only: got %b/%b exp 01/00", forward_a, forward_b); end
        drain();
    endtask

    task automatic test_branch();
        set_rtype(5'd1, 5'd2, 5'd8);
        ex_branch_taken = 1'b1;
        #1;
        n_chk++; if (ifid_flush !== 1'b1) begin n_fail++; $display("FAIL br_ifid_flush: got %b exp 1", ifid_flush); end
        n_chk++; if (pc_write !== 1'b1 || ifid_write !== 1'b1)
            begin n_fail++; $display("FAIL br_pc_ifid_write: got %b/%b exp 1/1", pc_write, ifid_write); end
        step();
        ex_branch_taken = 1'b0;
        set_idle();
        n_chk++; if ({ex_aluop, ex_alusrc, ex_branch} !== 4'b0000)
            begin n_fail++; $display("FAIL br_bubble: got %b exp 0000", {ex_aluop, ex_alusrc, ex_branch}); end
        n_chk++; if (flush_cnt !== 4'd1) begin n_fail++; $display("FAIL br_flush_cnt: got %0d exp 1", flush_cnt); end
        drain();
    endtask

    task automatic test_branch_stall();
        set_ld(5'd1, 5'd5); step();
        set_rtype(5'd5, 5'd7, 5'd6);
        ex_branch_taken = 1'b1;
        #1;
        n_chk++; if (pc_write !== 1'b1 || ifid_flush !== 1'b1)
            begin n_fail++; $display("FAIL bs_branch_wins: got %b/%b exp 1/1", pc_write, ifid_flush); end
        step();
        ex_branch_taken = 1'b0;
        set_idle();
        n_chk++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL bs_stall_cnt: got %0d exp 1", stall_cnt); end
        n_chk++; if (flush_cnt !== 4'd2) begin n_fail++; $display("FAIL bs_flush_cnt: got %0d exp 2", flush_cnt); end
        n_chk++; if (ex_aluop !== 2'b00) begin n_fail++; $display("FAIL bs_bubble: got %b exp 00", ex_aluop); end
        drain();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            set_ld(5'd1, 5'd5); step();
            set_rtype(5'd5, 5'd7, 5'd6); step();
            if (i == 12) begin
                n_chk++; if (stall_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_before: got %0d exp 14", stall_cnt); end
            end
            if (i == 13) begin
                n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d exp 15", stall_cnt); end
            end
        end
        n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d exp 15", stall_cnt); end
        n_chk++; if (flush_cnt !== 4'd2)  begin n_fail++; $display("FAIL sat_flush_cnt: got %0d exp 2", flush_cnt); end
        drain();
    endtask

    task automatic test_reset_mid();
        set_ld(5'd1, 5'd5); step();
        n_chk++; if (ex_alusrc !== 1'b1) begin n_fail++; $display("FAIL rm_ld_in_ex: got %b exp 1", ex_alusrc); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_idle();
        n_chk++; if (mem_memread !== 1'b0 || mem_rd !== 5'd0)
            begin n_fail++; $display("FAIL rm_mem_dropped: got %b/%0d exp 0/0", mem_memread, mem_rd); end
        n_chk++; if (ex_alusrc !== 1'b0) begin n_fail++; $display("FAIL rm_ex_dropped: got %b exp 0", ex_alusrc); end
        n_chk++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
            begin n_fail++; $display("FAIL rm_counters: got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        ex_branch_taken = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_forward_priority();
        test_branch();
        test_branch_stall();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
